// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a sync_fifo read port and shifts each word out as an
// asynchronous UART frame (start, LSB-first data, optional even parity, stop).
// One word is popped per frame; the FIFO is only examined while idle.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  // frame_done is registered, so it is armed one cycle before the last stop cycle
  localparam logic [BAUD_W-1:0] BAUD_PRE   = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
  localparam logic              STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic              HAS_PARITY = (PARITY_EN != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  state_t                  state_r;
  logic [BAUD_W-1:0]       baud_r;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic                    stop_cnt_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic                    parity_r;
  logic                    tx_r;
  logic                    rd_en_r;
  logic                    busy_r;
  logic                    done_r;

  // Even parity bit: makes the total count of ones over data plus parity even.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] data);
    return ^data;
  endfunction

  // Frame sequencer: state, counters, shift register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      baud_r     <= {BAUD_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      stop_cnt_r <= 1'b0;
      shift_r    <= {DATA_WIDTH{1'b0}};
      parity_r   <= 1'b0;
      tx_r       <= 1'b1;
      rd_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      rd_en_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tx_r       <= 1'b1;
          baud_r     <= {BAUD_W{1'b0}};
          bit_cnt_r  <= {BIT_W{1'b0}};
          stop_cnt_r <= 1'b0;
          if (!fifo_empty) begin
            state_r <= ST_READ;
            rd_en_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_READ: begin
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          // FIFO output is valid this cycle; the start bit begins next cycle
          shift_r  <= fifo_rdata;
          parity_r <= even_parity(fifo_rdata);
          tx_r     <= 1'b0;
          state_r  <= ST_START;
        end
        ST_START: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= {BAUD_W{1'b0}};
            tx_r    <= shift_r[0];
            state_r <= ST_DATA;
          end else begin
            baud_r  <= baud_r + BAUD_W'(1'b1);
          end
        end
        ST_DATA: begin
          if (baud_r == BAUD_LAST) begin
            baud_r <= {BAUD_W{1'b0}};
            if (bit_cnt_r == BIT_LAST) begin
              bit_cnt_r <= {BIT_W{1'b0}};
              if (HAS_PARITY) begin
                tx_r    <= parity_r;
                state_r <= ST_PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= ST_STOP;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
              shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1'b1);
          end
        end
        ST_PARITY: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= {BAUD_W{1'b0}};
            tx_r    <= 1'b1;
            state_r <= ST_STOP;
          end else begin
            baud_r  <= baud_r + BAUD_W'(1'b1);
          end
        end
        ST_STOP: begin
          tx_r <= 1'b1;
          if (baud_r == BAUD_LAST) begin
            baud_r <= {BAUD_W{1'b0}};
            if (stop_cnt_r == STOP_LAST) begin
              stop_cnt_r <= 1'b0;
              busy_r     <= 1'b0;
              state_r    <= ST_IDLE;
            end else begin
              stop_cnt_r <= 1'b1;
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1'b1);
            if ((baud_r == BAUD_PRE) && (stop_cnt_r == STOP_LAST)) begin
              done_r <= 1'b1;
            end else begin
              done_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

endmodule
